// File: rtl/alu_arbiter.sv
// Two-requester front end to a shared combinational ALU, with one registered response slot each.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; the default build uses fixed priority.
module alu_arbiter #(
    parameter int unsigned CMDW = 16,
    parameter int unsigned TAGW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0][CMDW-1:0] req_cmd,
    input  logic [1:0][31:0]     req_a,
    input  logic [1:0][31:0]     req_b,
    input  logic [1:0][TAGW-1:0] req_tag,
    output logic [CMDW-1:0]      alu_cmd,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_rd_data,
    input  logic                 alu_branch,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [1:0][31:0]     rsp_data,
    output logic [1:0]           rsp_branch,
    output logic [1:0][TAGW-1:0] rsp_tag
);

    logic [1:0]           rsp_valid_q;
    logic [1:0][31:0]     rsp_data_q;
    logic [1:0]           rsp_branch_q;
    logic [1:0][TAGW-1:0] rsp_tag_q;

    logic [1:0] eligible;
    logic [1:0] grant;

    // A slot that is being drained this cycle can accept a new result without a bubble.
    assign eligible = req_valid & (~rsp_valid_q | rsp_ready);

`ifdef ALU_ARBITER_RR_EN
    logic last_q;

    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|req_ready) begin
            last_q <= req_ready[1];
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (eligible[0]) begin
            grant = 2'b01;
        end else if (eligible[1]) begin
            grant = 2'b10;
        end
    end
`endif

    assign req_ready = rst_n ? grant : 2'b00;

    always_comb begin
        alu_cmd = '0;
        alu_a   = '0;
        alu_b   = '0;
        if (req_ready[0]) begin
            alu_cmd = req_cmd[0];
            alu_a   = req_a[0];
            alu_b   = req_b[0];
        end else if (req_ready[1]) begin
            alu_cmd = req_cmd[1];
            alu_a   = req_a[1];
            alu_b   = req_b[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_branch_q <= '0;
            rsp_tag_q    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    rsp_valid_q[i]  <= 1'b1;
                    rsp_data_q[i]   <= alu_rd_data;
                    rsp_branch_q[i] <= alu_branch;
                    rsp_tag_q[i]    <= req_tag[i];
                end else if (rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_branch = rsp_branch_q;
    assign rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner sequences and random traffic
// checked against a slot-level reference model. Honours ALU_ARBITER_RR_EN like the design.
module tb_alu_arbiter;

    localparam int CMDW = 16;
    localparam int TAGW = 4;
    localparam logic [CMDW-1:0] OP_ADD = 16'd0;
    localparam logic [CMDW-1:0] OP_SUB = 16'd1;
    localparam logic [CMDW-1:0] OP_XOR = 16'd2;
    localparam logic [CMDW-1:0] OP_BLT = 16'd3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][CMDW-1:0] req_cmd;
    logic [1:0][31:0]     req_a;
    logic [1:0][31:0]     req_b;
    logic [1:0][TAGW-1:0] req_tag;
    logic [CMDW-1:0]      alu_cmd;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [31:0]          alu_rd_data;
    logic                 alu_branch;
    logic [1:0]           rsp_valid;
    logic [1:0]           rsp_ready;
    logic [1:0][31:0]     rsp_data;
    logic [1:0]           rsp_branch;
    logic [1:0][TAGW-1:0] rsp_tag;

    always #5 clk = ~clk;

    alu_arbiter #(.CMDW(CMDW), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .alu_cmd    (alu_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_rd_data(alu_rd_data),
        .alu_branch (alu_branch),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_branch (rsp_branch),
        .rsp_tag    (rsp_tag)
    );

    // Toy ALU environment: returns {branch, result}.
    function automatic logic [32:0] alu_fn(logic [CMDW-1:0] c, logic [31:0] a, logic [31:0] b);
        logic lt;
        lt = ($signed(a) < $signed(b));
        case (c[1:0])
            2'd0:    return {1'b0, a + b};
            2'd1:    return {1'b0, a - b};
            2'd2:    return {1'b0, a ^ b};
            default: return {lt, 31'd0, lt};
        endcase
    endfunction

    assign {alu_branch, alu_rd_data} = alu_fn(alu_cmd, alu_a, alu_b);

    // Reference model: contents of each response slot plus the last winner.
    bit              m_full [2];
    logic [31:0]     m_data [2];
    logic            m_br   [2];
    logic [TAGW-1:0] m_tag  [2];
    int              m_last;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner under the arbitration rules: -1 none, else requester index.
    function automatic int winner();
        bit can [2];
        for (int i = 0; i < 2; i++) can[i] = req_valid[i] && (!m_full[i] || rsp_ready[i]);
        if (can[0] && can[1]) begin
`ifdef ALU_ARBITER_RR_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (can[0]) return 0;
        if (can[1]) return 1;
        return -1;
    endfunction

    task automatic check_rsp(input string name);
        chk({name, " rsp_valid"}, {62'd0, rsp_valid}, {62'd0, m_full[1], m_full[0]});
        for (int i = 0; i < 2; i++) begin
            if (m_full[i]) begin
                chk({name, " rsp_data"}, {32'd0, rsp_data[i]}, {32'd0, m_data[i]});
                chk({name, " rsp_branch"}, {63'd0, rsp_branch[i]}, {63'd0, m_br[i]});
                chk({name, " rsp_tag"}, {60'd0, rsp_tag[i]}, {60'd0, m_tag[i]});
            end
        end
    endtask

    // Called just after a negedge with inputs already driven; ends at the next negedge.
    task automatic step(input string name);
        int w;
        logic [1:0] g;
        logic [32:0] r;
        #1;
        w = winner();
        g = (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10);
        chk({name, " req_ready"}, {62'd0, req_ready}, {62'd0, g});
        chk({name, " alu_cmd"}, {48'd0, alu_cmd}, (w < 0) ? 64'd0 : {48'd0, req_cmd[w]});
        chk({name, " alu_a"}, {32'd0, alu_a}, (w < 0) ? 64'd0 : {32'd0, req_a[w]});
        chk({name, " alu_b"}, {32'd0, alu_b}, (w < 0) ? 64'd0 : {32'd0, req_b[w]});
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (w == i) begin
                r = alu_fn(req_cmd[i], req_a[i], req_b[i]);
                m_full[i] = 1'b1;
                m_data[i] = r[31:0];
                m_br[i]   = r[32];
                m_tag[i]  = req_tag[i];
            end else if (rsp_ready[i]) begin
                m_full[i] = 1'b0;
            end
        end
        if (w >= 0) m_last = w;
        @(negedge clk);
        check_rsp(name);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({name, " rst rsp_valid"}, {62'd0, rsp_valid}, 64'd0);
        chk({name, " rst rsp_data"}, rsp_data, 64'd0);
        chk({name, " rst rsp_tag"}, {56'd0, rsp_tag, rsp_branch}, 64'd0);
        chk({name, " rst req_ready"}, {62'd0, req_ready}, 64'd0);
        chk({name, " rst alu_out"}, {alu_a, alu_b} | {48'd0, alu_cmd}, 64'd0);
        for (int i = 0; i < 2; i++) m_full[i] = 1'b0;
        m_last = 1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [CMDW-1:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAGW-1:0] t);
        req_cmd[i] = c;
        req_a[i]   = a;
        req_b[i]   = b;
        req_tag[i] = t;
    endtask

    typedef struct {
        logic [1:0]      v;
        logic [1:0]      rr;
        logic [CMDW-1:0] c0;
        logic [31:0]     a0;
        logic [31:0]     b0;
        logic [CMDW-1:0] c1;
        logic [31:0]     a1;
        logic [31:0]     b1;
        logic [1:0]      x_ready;
        logic [1:0]      x_valid;
        logic [31:0]     x_data0;
        logic            x_br0;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [1:0] xg;

        tbl[0] = '{2'b01, 2'b00, OP_ADD, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0,
                   2'b01, 2'b01, 32'd12, 1'b0};
        tbl[1] = '{2'b10, 2'b00, OP_ADD, 32'd0, 32'd0, OP_SUB, 32'd10, 32'd3,
                   2'b10, 2'b11, 32'd12, 1'b0};
        tbl[2] = '{2'b11, 2'b00, OP_ADD, 32'd1, 32'd1, OP_ADD, 32'd2, 32'd2,
                   2'b00, 2'b11, 32'd12, 1'b0};
        tbl[3] = '{2'b01, 2'b01, OP_XOR, 32'd3, 32'd4, OP_ADD, 32'd0, 32'd0,
                   2'b01, 2'b11, 32'd7, 1'b0};
        tbl[4] = '{2'b00, 2'b11, OP_ADD, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0,
                   2'b00, 2'b00, 32'd0, 1'b0};
        tbl[5] = '{2'b01, 2'b00, OP_BLT, 32'hffff_ffff, 32'd0, OP_ADD, 32'd0, 32'd0,
                   2'b01, 2'b01, 32'd1, 1'b1};
        tbl[6] = '{2'b01, 2'b01, OP_BLT, 32'd0, 32'hffff_ffff, OP_ADD, 32'd0, 32'd0,
                   2'b01, 2'b01, 32'd0, 1'b0};
        tbl[7] = '{2'b00, 2'b01, OP_ADD, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0,
                   2'b00, 2'b00, 32'd0, 1'b0};

        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_cmd = '0;
        req_a = '0;
        req_b = '0;
        req_tag = '0;
        for (int i = 0; i < 2; i++) m_full[i] = 1'b0;
        m_last = 1;
        repeat (2) @(negedge clk);
        do_reset("init");

        // Vector table straight out of reset.
        for (int k = 0; k < 8; k++) begin
            req_valid = tbl[k].v;
            rsp_ready = tbl[k].rr;
            set_req(0, tbl[k].c0, tbl[k].a0, tbl[k].b0, TAGW'(k));
            set_req(1, tbl[k].c1, tbl[k].a1, tbl[k].b1, TAGW'(k + 8));
            #1 chk($sformatf("vec%0d ready", k), {62'd0, req_ready}, {62'd0, tbl[k].x_ready});
            step($sformatf("vec%0d", k));
            chk($sformatf("vec%0d valid", k), {62'd0, rsp_valid}, {62'd0, tbl[k].x_valid});
            if (tbl[k].x_valid[0]) begin
                chk($sformatf("vec%0d data0", k), {32'd0, rsp_data[0]}, {32'd0, tbl[k].x_data0});
                chk($sformatf("vec%0d br0", k), {63'd0, rsp_branch[0]}, {63'd0, tbl[k].x_br0});
            end
        end

        // Persistent conflict with both slots draining.
        do_reset("alt");
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 8; k++) begin
            set_req(0, OP_ADD, $urandom, $urandom, TAGW'($urandom));
            set_req(1, OP_SUB, $urandom, $urandom, TAGW'($urandom));
`ifdef ALU_ARBITER_RR_EN
            xg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            xg = 2'b01;
`endif
            #1 chk("alt grant", {62'd0, req_ready}, {62'd0, xg});
            step("alt");
        end

        // Slot 0 held full: requester 1 keeps flowing, requester 0 stalls.
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        step("drain");
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        set_req(0, OP_ADD, 32'd100, 32'd1, 4'd9);
        step("fill0");
        req_valid = 2'b11;
        rsp_ready = 2'b10;
        for (int k = 0; k < 4; k++) begin
            set_req(0, OP_XOR, $urandom, $urandom, TAGW'($urandom));
            set_req(1, OP_ADD, $urandom, $urandom, TAGW'($urandom));
            #1 chk("stall0 grant", {62'd0, req_ready}, 64'd2);
            step("stall0");
        end
        rsp_ready = 2'b11;
        step("release0");

        // Reset with both slots full and requests pending.
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        step("fullA");
        step("fullB");
        chk("both full", {62'd0, rsp_valid}, 64'd3);
        do_reset("midrst");
        #1 chk("post rst grant", {62'd0, req_ready}, 64'd1);
        step("postrst");

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            req_valid = 2'($urandom);
            rsp_ready = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                set_req(i, CMDW'($urandom_range(0, 3)),
                        ($urandom_range(0, 3) == 0) ? 32'hffff_fff0 + $urandom_range(0, 31) : $urandom,
                        ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, TAGW'($urandom));
            end
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CMDW, default 16, width of the opaque ALU command bundle (alu_op, is_imm, is_store_op, is_auipc, comp_op, subtract, shift_right, shift_arith, packed by the requester).
REQ-002 Parameter TAGW, default 4, width of the requester tag returned with each response.
REQ-003 clk  input  1  the block's single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  [1:0]  per-requester request valid.
REQ-006 req_ready  output  [1:0]  per-requester request accepted this cycle.
REQ-007 req_cmd  input  [1:0][CMDW-1:0]  per-requester ALU command bundle.
REQ-008 req_a, req_b  input  [1:0][31:0]  per-requester operands (rs1/PC side, rs2/imm side).
REQ-009 req_tag  input  [1:0][TAGW-1:0]  per-requester opaque tag.
REQ-010 alu_cmd, alu_a, alu_b  output  CMDW/32/32  forwarded to the shared combinational ALU.
REQ-011 alu_rd_data, alu_branch  input  32/1  ALU result and branch/compare flag, same cycle.
REQ-012 rsp_valid  output  [1:0]  per-requester response valid.
REQ-013 rsp_ready  input  [1:0]  per-requester response consumed.
REQ-014 rsp_data, rsp_branch, rsp_tag  output  [1:0] x 32/1/TAGW  registered response.

Function
REQ-015 Each requester SHALL own a one-entry response slot, EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
REQ-016 Requester i SHALL be eligible when req_valid[i]=1 and its slot is EMPTY or draining (rsp_valid[i]&rsp_ready[i]) this cycle.
REQ-017 At most one requester SHALL be granted per cycle; req_ready[i]=1 only for the granted eligible requester.
REQ-018 The granted requester's cmd/a/b SHALL drive alu_cmd/alu_a/alu_b combinationally; with no grant these outputs SHALL be all-zero.
REQ-019 On a handshake (req_valid[i]&req_ready[i]) at edge N, alu_rd_data, alu_branch and req_tag[i] SHALL be captured into slot i; rsp_valid[i]=1 from cycle N+1 (latency 1).
REQ-020 A FULL slot SHALL hold rsp_data/rsp_branch/rsp_tag stable until rsp_ready[i]=1; drain clears rsp_valid[i] next cycle unless refilled.
REQ-021 Simultaneous drain and new accept on the same slot SHALL leave rsp_valid[i]=1 with the new data next cycle, no bubble.
REQ-022 Both eligible SHALL be resolved per REQ-030; a single eligible requester SHALL always be granted.
REQ-023 A requester with a FULL, non-draining slot SHALL NOT be granted; the other requester SHALL proceed unaffected.
REQ-024 Request fields SHALL NOT be read or retained for ungranted requesters; no request is ever dropped or duplicated.

Reset
REQ-025 rst_n low SHALL asynchronously clear rsp_valid to 2'b00, rsp_data/rsp_branch/rsp_tag to 0, and the last-grant pointer to 1.
REQ-026 req_ready SHALL be 2'b00 and alu_cmd/alu_a/alu_b zero while rst_n is low.
REQ-027 Responses pending at reset SHALL be discarded; first grant after release follows REQ-030 from pointer=1.
REQ-028 Deassertion of rst_n SHALL be treated as synchronous to clk by the integrator; no internal synchronizer.

Configuration
REQ-029 Macro ALU_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-030 Defined: round-robin; on conflict grant the requester not equal to the last-grant pointer; pointer updates only on a handshake; eligible requester granted within 2 cycles. Undefined: fixed priority, requester 0 always wins conflicts; pointer register not implemented.

Verification
REQ-031 Reset then req_valid=01, cmd=ADD, a=5, b=7 -> req_ready=01 same cycle, next cycle rsp_valid=01, rsp_data[0]=12, tag echoed.
REQ-032 Both valid every cycle, rsp_ready=11, RR_EN defined -> grants alternate 0,1,0,1 starting with 0; undefined -> requester 0 every cycle, requester 1 never.
REQ-033 Slot 0 FULL, rsp_ready[0]=0, both valid -> requester 1 granted every cycle, req_ready[0]=0 until rsp_ready[0]=1.
REQ-034 Slot 0 FULL with rsp_ready[0]=1 and new req 0 (a=3, b=4, XOR) -> accepted same cycle, rsp_valid[0] stays 1, rsp_data[0]=7 next cycle.
REQ-035 rst_n pulsed low while both slots FULL -> rsp_valid=00 immediately, outputs zero, first post-reset conflict granted to requester 0.
REQ-036 Compare op BLT a=-1, b=0 -> rsp_branch=1; a=0, b=-1 -> rsp_branch=0, tags returned unchanged.
